nnrv_regfile: RTL and testbench
===============================

NNRV_REGFILE -- requirements
Module: nnrv_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 64, integer register width.
REQ-002 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_reg_w_en  input  1  writeback write enable.
REQ-005 SHALL have port i_reg_w  input  5  writeback destination index.
REQ-006 SHALL have port i_reg_w_reg  input  XLEN  writeback data.
REQ-007 SHALL have port i_rs1  input  5  read port 1 index.
REQ-008 SHALL have port i_rs2  input  5  read port 2 index.
REQ-009 SHALL have port o_rs1_reg  output  XLEN  read port 1 data.
REQ-010 SHALL have port o_rs2_reg  output  XLEN  read port 2 data.
REQ-011 SHALL have port i_sb_set_en  input  1  issue marks a destination pending.
REQ-012 SHALL have port i_sb_set  input  5  index marked pending.
REQ-013 SHALL have port o_rs1_busy  output  1  rs1 has an outstanding write.
REQ-014 SHALL have port o_rs2_busy  output  1  rs2 has an outstanding write.

Function
REQ-015 SHALL hold 31 XLEN-bit registers x1..x31; x0 SHALL always read 0.
REQ-016 Write: on rising i_clk with i_reg_w_en=1 and i_reg_w!=0, register i_reg_w SHALL take i_reg_w_reg; writes to x0 SHALL be discarded.
REQ-017 Reads SHALL be combinational from i_rs1/i_rs2 (zero-cycle latency); both ports may address the same register.
REQ-018 Scoreboard: one pending bit per x1..x31; bit for x0 SHALL be constant 0.
REQ-019 On rising i_clk, i_sb_set_en=1 and i_sb_set!=0 SHALL set pending[i_sb_set].
REQ-020 On rising i_clk, i_reg_w_en=1 SHALL clear pending[i_reg_w].
REQ-021 Set and clear of the same index in one cycle: set SHALL win (new producer outstanding).
REQ-022 Clear of an already-clear bit and set of an already-set bit SHALL be no-ops.
REQ-023 o_rsN_busy SHALL equal pending[i_rsN] combinationally, excluding same-cycle writeback per REQ-026/027.

Reset
REQ-024 While i_rst=1, all registers SHALL be 0 and all pending bits 0, independent of i_clk.
REQ-025 Writes and scoreboard sets SHALL be ignored on any edge where i_rst=1; after release, outputs reflect zeroed state (o_rsN_reg=0, o_rsN_busy=0).

Configuration
REQ-026 With NNRV_REGFILE_BYPASS_EN defined: if i_reg_w_en=1, i_reg_w!=0 and i_reg_w==i_rsN, o_rsN_reg SHALL equal i_reg_w_reg and o_rsN_busy SHALL be 0 in the same cycle (unless set again same cycle per REQ-021 only affects next cycle).
REQ-027 Without NNRV_REGFILE_BYPASS_EN: o_rsN_reg SHALL show the stored value (new data visible one cycle after the write edge) and o_rsN_busy SHALL show pending until the edge.

Structure
REQ-028 Register-index width (5), register count (32) and x0 index SHALL be constants in the shared nnrv package.
REQ-029 No sub-module; storage array and scoreboard SHALL reside in nnrv_regfile.

Verification
REQ-030 Reset: assert i_rst mid-run after writing x5=0x1234 -> o_rs1_reg (i_rs1=5)=0 immediately, busy=0.
REQ-031 Write/read: write x7=0xDEADBEEF, next cycle i_rs1=7, i_rs2=7 -> both read 0xDEADBEEF.
REQ-032 x0: write x0=0xFFFF, set pending x0 -> i_rs1=0 reads 0, o_rs1_busy=0.
REQ-033 Scoreboard: set x3 cycle 0 -> o_rs1_busy=1 (i_rs1=3) from cycle 1; writeback x3=0x55 at cycle 4 -> busy=0 cycle 5; simultaneous set+write x3 -> busy stays 1.
REQ-034 Bypass: same-cycle write x9=0xA5 with i_rs2=9 -> o_rs2_reg=0xA5, busy=0 with NNRV_REGFILE_BYPASS_EN; old value and busy=1 without.

Source files
------------

// File: rtl/nnrv_pkg.sv
// nnrv_pkg -- constants and helpers shared by the nnrv integer core blocks.
//   REG_IDX_W : architectural register index width
//   REG_COUNT : number of architectural integer registers (x0..x31)
//   REG_X0    : index of the hard-wired zero register
package nnrv_pkg;

    localparam int REG_IDX_W = 5;
    localparam int REG_COUNT = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_X0 = '0;

    // True for any index that names real storage (everything but x0).
    function automatic logic idx_live(input reg_idx_t idx);
        return idx != REG_X0;
    endfunction

endpackage

// File: rtl/nnrv_regfile.sv
// nnrv_regfile -- integer register file with an issue scoreboard.
//
// Holds x1..x31. x0 always reads as zero, and x0 is never marked pending.
// There are two combinational read ports and one clocked writeback port.
// Each register has one pending bit. Issue sets the bit. Writeback clears
// the bit. When both happen to the same index on the same edge, the set
// wins, because a new producer is now outstanding.
//
// Optional feature (define NNRV_REGFILE_BYPASS_EN):
//   Writeback data is forwarded to a read port in the same cycle when the
//   indices match. That read port's busy output is then suppressed.
//   Without the define, new data becomes visible one cycle after the
//   write edge.
//
// Ports:
//   i_clk, i_rst                      clock (rising edge), async active-high reset
//   i_reg_w_en, i_reg_w, i_reg_w_reg  writeback enable / index / data
//   i_rs1, i_rs2                      read indices
//   o_rs1_reg, o_rs2_reg              read data
//   i_sb_set_en, i_sb_set             mark a destination pending at issue
//   o_rs1_busy, o_rs2_busy            read source has an outstanding write
module nnrv_regfile
    import nnrv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_reg_w_en,
    input  logic [REG_IDX_W-1:0] i_reg_w,
    input  logic [XLEN-1:0]      i_reg_w_reg,
    input  logic [REG_IDX_W-1:0] i_rs1,
    input  logic [REG_IDX_W-1:0] i_rs2,
    output logic [XLEN-1:0]      o_rs1_reg,
    output logic [XLEN-1:0]      o_rs2_reg,
    input  logic                 i_sb_set_en,
    input  logic [REG_IDX_W-1:0] i_sb_set,
    output logic                 o_rs1_busy,
    output logic                 o_rs2_busy
);

    // Entry 0 is never written. It is also masked on read, so x0 costs
    // nothing after synthesis.
    logic [XLEN-1:0]      regs [REG_COUNT];
    logic [REG_COUNT-1:0] pending;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            regs <= '{default: '0};
        end else if (i_reg_w_en && idx_live(i_reg_w)) begin
            regs[i_reg_w] <= i_reg_w_reg;
        end
    end

    // The set is placed after the clear, so the later non-blocking
    // assignment wins on an index collision.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pending <= '0;
        end else begin
            if (i_reg_w_en) pending[i_reg_w] <= 1'b0;
            if (i_sb_set_en && idx_live(i_sb_set)) pending[i_sb_set] <= 1'b1;
        end
    end

    logic [XLEN-1:0] rs1_stored, rs2_stored;
    logic            rs1_pend,   rs2_pend;

    always_comb begin
        rs1_stored = idx_live(i_rs1) ? regs[i_rs1] : '0;
        rs2_stored = idx_live(i_rs2) ? regs[i_rs2] : '0;
        rs1_pend   = idx_live(i_rs1) & pending[i_rs1];
        rs2_pend   = idx_live(i_rs2) & pending[i_rs2];
    end

`ifdef NNRV_REGFILE_BYPASS_EN
    // Forwarding is gated by reset, so nothing but zero can leak out
    // while the file is held in reset.
    logic wb_live, rs1_hit, rs2_hit;

    always_comb begin
        wb_live    = ~i_rst & i_reg_w_en & idx_live(i_reg_w);
        rs1_hit    = wb_live & (i_reg_w == i_rs1);
        rs2_hit    = wb_live & (i_reg_w == i_rs2);
        o_rs1_reg  = rs1_hit ? i_reg_w_reg : rs1_stored;
        o_rs2_reg  = rs2_hit ? i_reg_w_reg : rs2_stored;
        o_rs1_busy = rs1_pend & ~rs1_hit;
        o_rs2_busy = rs2_pend & ~rs2_hit;
    end
`else
    always_comb begin
        o_rs1_reg  = rs1_stored;
        o_rs2_reg  = rs2_stored;
        o_rs1_busy = rs1_pend;
        o_rs2_busy = rs2_pend;
    end
`endif

endmodule

// File: tb/tb_nnrv_regfile.sv
// tb_nnrv_regfile -- self-checking bench for nnrv_regfile.
// Reference model: a plain array of register values and a pending-bit
// array. These are updated from the architectural rules at every rising
// edge. Inputs are driven after the falling edge. Outputs are checked
// in the low phase.
// Honours NNRV_REGFILE_BYPASS_EN in the same way as the design.
module tb_nnrv_regfile;

    localparam int XLEN = 64;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_reg_w_en;
    logic [4:0]      i_reg_w;
    logic [XLEN-1:0] i_reg_w_reg;
    logic [4:0]      i_rs1, i_rs2;
    logic [XLEN-1:0] o_rs1_reg, o_rs2_reg;
    logic            i_sb_set_en;
    logic [4:0]      i_sb_set;
    logic            o_rs1_busy, o_rs2_busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [XLEN-1:0] m_reg  [32];
    bit              m_pend [32];

`ifdef NNRV_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    nnrv_regfile #(.XLEN(XLEN)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_reg_w_en(i_reg_w_en), .i_reg_w(i_reg_w), .i_reg_w_reg(i_reg_w_reg),
        .i_rs1(i_rs1), .i_rs2(i_rs2),
        .o_rs1_reg(o_rs1_reg), .o_rs2_reg(o_rs2_reg),
        .i_sb_set_en(i_sb_set_en), .i_sb_set(i_sb_set),
        .o_rs1_busy(o_rs1_busy), .o_rs2_busy(o_rs2_busy)
    );

    always #5 i_clk = ~i_clk;

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endfunction

    // Value a read port should present this cycle.
    function automatic logic [XLEN-1:0] exp_rd(input logic [4:0] idx);
        if (idx == 0 || i_rst) return '0;
        if (BYPASS && i_reg_w_en && i_reg_w == idx) return i_reg_w_reg;
        return m_reg[idx];
    endfunction

    function automatic logic exp_busy(input logic [4:0] idx);
        if (idx == 0 || i_rst) return 1'b0;
        if (BYPASS && i_reg_w_en && i_reg_w == idx) return 1'b0;
        return m_pend[idx];
    endfunction

    // Drive one cycle's inputs in the low phase.
    task automatic drive(input logic we, input logic [4:0] w, input logic [XLEN-1:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic se, input logic [4:0] s);
        @(negedge i_clk);
        i_reg_w_en = we; i_reg_w = w; i_reg_w_reg = wd;
        i_rs1 = r1; i_rs2 = r2; i_sb_set_en = se; i_sb_set = s;
        #1;
    endtask

    // Advance through the rising edge and apply the architectural rules.
    task automatic tick();
        @(posedge i_clk);
        if (!i_rst) begin
            if (i_reg_w_en && i_reg_w != 0) m_reg[i_reg_w] = i_reg_w_reg;
            if (i_reg_w_en) m_pend[i_reg_w] = 1'b0;
            if (i_sb_set_en && i_sb_set != 0) m_pend[i_sb_set] = 1'b1;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        drive(1'b1, 5'd4, 64'hABCD, 5'd4, 5'd0, 1'b1, 5'd4);
        tick();
        drive(1'b0, 5'd0, '0, 5'd4, 5'd4, 1'b0, 5'd0);
        n_checks++;
        if (o_rs1_reg !== '0 || o_rs1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: reg=%h busy=%b want 0/0", o_rs1_reg, o_rs1_busy);
        end
        i_rst = 1'b0;
        #1;
        n_checks++;
        if (o_rs2_reg !== '0 || o_rs2_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: reg=%h busy=%b want 0/0", o_rs2_reg, o_rs2_busy);
        end
    endtask

    task automatic test_write_read();
        drive(1'b1, 5'd7, 64'hDEADBEEF, 5'd1, 5'd2, 1'b0, 5'd0);
        tick();
        drive(1'b0, 5'd0, '0, 5'd7, 5'd7, 1'b0, 5'd0);
        n_checks++;
        if (o_rs1_reg !== 64'hDEADBEEF || o_rs2_reg !== 64'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write_read: rs1=%h rs2=%h want deadbeef", o_rs1_reg, o_rs2_reg);
        end
        tick();
    endtask

    task automatic test_x0();
        drive(1'b1, 5'd0, 64'hFFFF, 5'd0, 5'd0, 1'b1, 5'd0);
        n_checks++;
        if (o_rs1_reg !== '0 || o_rs1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_same: reg=%h busy=%b want 0/0", o_rs1_reg, o_rs1_busy);
        end
        tick();
        drive(1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, 5'd0);
        n_checks++;
        if (o_rs1_reg !== '0 || o_rs1_busy !== 1'b0 || o_rs2_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_next: reg=%h busy=%b want 0/0", o_rs1_reg, o_rs1_busy);
        end
        tick();
    endtask

    task automatic test_scoreboard();
        drive(1'b0, 5'd0, '0, 5'd3, 5'd0, 1'b1, 5'd3);
        tick();
        for (int c = 1; c <= 3; c++) begin
            drive(1'b0, 5'd0, '0, 5'd3, 5'd0, 1'b0, 5'd0);
            n_checks++;
            if (o_rs1_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL sb_pending c%0d: busy=%b want 1", c, o_rs1_busy);
            end
            tick();
        end
        drive(1'b1, 5'd3, 64'h55, 5'd3, 5'd0, 1'b0, 5'd0);
        n_checks++;
        if (o_rs1_busy !== !BYPASS) begin
            n_fail++;
            $display("FAIL sb_wb_cycle: busy=%b want %b", o_rs1_busy, !BYPASS);
        end
        tick();
        drive(1'b0, 5'd0, '0, 5'd3, 5'd0, 1'b0, 5'd0);
        n_checks++;
        if (o_rs1_busy !== 1'b0 || o_rs1_reg !== 64'h55) begin
            n_fail++;
            $display("FAIL sb_cleared: busy=%b reg=%h want 0/55", o_rs1_busy, o_rs1_reg);
        end
        tick();
        // A second producer set on the writeback edge must stay outstanding.
        drive(1'b0, 5'd0, '0, 5'd3, 5'd0, 1'b1, 5'd3);
        tick();
        drive(1'b1, 5'd3, 64'h66, 5'd3, 5'd0, 1'b1, 5'd3);
        tick();
        drive(1'b0, 5'd0, '0, 5'd3, 5'd3, 1'b0, 5'd0);
        n_checks++;
        if (o_rs1_busy !== 1'b1 || o_rs2_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_set_wins: busy1=%b busy2=%b want 1/1", o_rs1_busy, o_rs2_busy);
        end
        tick();
        // A clear of an already-clear bit is a no-op.
        drive(1'b1, 5'd12, 64'h1, 5'd12, 5'd0, 1'b0, 5'd0);
        tick();
        drive(1'b0, 5'd0, '0, 5'd12, 5'd0, 1'b0, 5'd0);
        n_checks++;
        if (o_rs1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_clear_noop: busy=%b want 0", o_rs1_busy);
        end
        tick();
    endtask

    task automatic test_bypass();
        drive(1'b1, 5'd9, 64'h11, 5'd0, 5'd0, 1'b1, 5'd9);
        tick();
        drive(1'b1, 5'd9, 64'hA5, 5'd1, 5'd9, 1'b0, 5'd0);
        n_checks++;
        if (BYPASS) begin
            if (o_rs2_reg !== 64'hA5 || o_rs2_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL bypass_on: reg=%h busy=%b want a5/0", o_rs2_reg, o_rs2_busy);
            end
        end else begin
            if (o_rs2_reg !== 64'h11 || o_rs2_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bypass_off: reg=%h busy=%b want 11/1", o_rs2_reg, o_rs2_busy);
            end
        end
        tick();
        drive(1'b0, 5'd0, '0, 5'd9, 5'd9, 1'b0, 5'd0);
        n_checks++;
        if (o_rs1_reg !== 64'hA5 || o_rs1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_after: reg=%h busy=%b want a5/0", o_rs1_reg, o_rs1_busy);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom), 5'($urandom_range(0, 7)));
            n_checks++;
            if (o_rs1_reg !== exp_rd(i_rs1) || o_rs2_reg !== exp_rd(i_rs2) ||
                o_rs1_busy !== exp_busy(i_rs1) || o_rs2_busy !== exp_busy(i_rs2)) begin
                n_fail++;
                $display("FAIL random c%0d: rs1=%0d %h/%b want %h/%b rs2=%0d %h/%b want %h/%b",
                         c, i_rs1, o_rs1_reg, o_rs1_busy, exp_rd(i_rs1), exp_busy(i_rs1),
                         i_rs2, o_rs2_reg, o_rs2_busy, exp_rd(i_rs2), exp_busy(i_rs2));
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 5'd5, 64'h1234, 5'd0, 5'd0, 1'b1, 5'd6);
        tick();
        drive(1'b0, 5'd0, '0, 5'd5, 5'd0, 1'b1, 5'd5);
        tick();
        drive(1'b0, 5'd0, '0, 5'd5, 5'd0, 1'b0, 5'd0);
        n_checks++;
        if (o_rs1_reg !== 64'h1234 || o_rs1_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: reg=%h busy=%b want 1234/1", o_rs1_reg, o_rs1_busy);
        end
        // Assert reset between edges: the clear must not wait for a clock.
        i_rst = 1'b1;
        #1;
        model_clear();
        n_checks++;
        if (o_rs1_reg !== '0 || o_rs1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: reg=%h busy=%b want 0/0", o_rs1_reg, o_rs1_busy);
        end
        // An edge seen while in reset ignores writes and sets.
        drive(1'b1, 5'd5, 64'h9999, 5'd5, 5'd6, 1'b1, 5'd5);
        tick();
        drive(1'b0, 5'd0, '0, 5'd5, 5'd6, 1'b0, 5'd0);
        i_rst = 1'b0;
        #1;
        n_checks++;
        if (o_rs1_reg !== '0 || o_rs1_busy !== 1'b0 || o_rs2_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ignores: reg=%h busy=%b/%b want 0/0/0",
                     o_rs1_reg, o_rs1_busy, o_rs2_busy);
        end
        tick();
    endtask

    initial begin
        i_rst = 1'b1;
        i_reg_w_en = 1'b0; i_reg_w = '0; i_reg_w_reg = '0;
        i_rs1 = '0; i_rs2 = '0; i_sb_set_en = 1'b0; i_sb_set = '0;
        model_clear();
        test_reset();
        test_write_read();
        test_x0();
        test_scoreboard();
        test_bypass();
        test_random();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
